// File: rtl/cache_if_pkg.sv
// Shared definitions for the cache refill/writeback interface:
// request type codes and the responder's state encoding.
package cache_if_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BUSY  = 2'd3
  } resp_state_t;

  // Only the line code selects a burst; every other code
  // (including the reserved ones) behaves as a single aligned word.
  function automatic logic is_line(input logic [2:0] t);
    return t == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_mem_responder_bram.sv
// Single-port RAM with per-lane write enables and registered read
// (read-before-write). Contents are never reset so it maps onto block RAM.
module bram #(
  parameter  int DEPTH      = 1024,
  parameter  int WIDTH      = 32,
  parameter  int WRITE_BYTE = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int LANES      = (WRITE_BYTE != 0) ? WIDTH / 8 : 1
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int LW = WIDTH / LANES;

  logic [WIDTH-1:0] mem [DEPTH];

  // Lane-masked write and synchronous read of the addressed word
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[addr][l*LW +: LW] <= wdata[l*LW +: LW];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refills, uncached reads, line writebacks
// and strobed uncached writes. One transaction at a time; writes win ties
// so a victim writeback always lands before the refill that follows it.
module cache_mem_responder
  import cache_if_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter int MEM_WORDS      = 16384,
  parameter int RD_LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rd_req,
  input  logic [2:0]                  rd_type,
  input  logic [31:0]                 rd_addr,
  output logic                        rd_rdy,
  output logic                        ret_valid,
  output logic [1:0]                  ret_last,
  output logic [31:0]                 ret_data,
  input  logic                        wr_req,
  input  logic [2:0]                  wr_type,
  input  logic [31:0]                 wr_addr,
  input  logic [3:0]                  wr_wstrb,
  input  logic [BYTES_PER_LINE*8-1:0] wr_data,
  output logic                        wr_rdy
);

  localparam int WORDS = BYTES_PER_LINE / 4;
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW-1:0] LINE_MASK = AW'(WORDS - 1);
  localparam logic [IW-1:0] LAST_LINE = IW'(WORDS - 1);
  localparam logic [3:0]    WAIT_LOAD = 4'(RD_LATENCY - 1);

  resp_state_t state, state_next;
  logic [AW-1:0]               base, base_next;
  logic [IW-1:0]               beat, beat_next;
  logic [IW-1:0]               last, last_next;
  logic [3:0]                  wait_cnt, wait_next;
  logic [3:0]                  strb_hold, strb_next;
  logic                        line_hold, line_next;
  logic [BYTES_PER_LINE*8-1:0] data_hold, data_next;

  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          rd_line, wr_line, rd_accept, wr_accept;
  logic [AW-1:0] rd_base, wr_base;
  logic [31:0]   hold_word [WORDS];
  logic          unused_bits;

  // Word slices of the held write line, indexed by beat during commit
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_hold_word
      assign hold_word[gi] = data_hold[32*gi +: 32];
    end
  endgenerate

  // Address bits above the RAM and the byte offset never select a word
  assign unused_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

  assign rd_line   = is_line(rd_type);
  assign wr_line   = is_line(wr_type);
  assign rd_base   = rd_line ? (rd_addr[AW+1:2] & ~LINE_MASK) : rd_addr[AW+1:2];
  assign wr_base   = wr_line ? (wr_addr[AW+1:2] & ~LINE_MASK) : wr_addr[AW+1:2];

  // Ready only in IDLE and out of reset; a pending write blocks the read
  assign wr_rdy    = resetn && (state == IDLE);
  assign rd_rdy    = wr_rdy && !wr_req;
  assign wr_accept = wr_req && wr_rdy;
  assign rd_accept = rd_req && rd_rdy;

  // Return data is forced to zero outside a burst so reset drives it low
  assign ret_data  = ret_valid ? ram_rdata : 32'h0;

  // State register and transaction holding registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      base      <= '0;
      beat      <= '0;
      last      <= '0;
      wait_cnt  <= '0;
      strb_hold <= '0;
      line_hold <= 1'b0;
      data_hold <= '0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      beat      <= beat_next;
      last      <= last_next;
      wait_cnt  <= wait_next;
      strb_hold <= strb_next;
      line_hold <= line_next;
      data_hold <= data_next;
    end
  end

  // Next-state, RAM port steering and return-channel outputs
  always_comb begin
    state_next = state;
    base_next  = base;
    beat_next  = beat;
    last_next  = last;
    wait_next  = wait_cnt;
    strb_next  = strb_hold;
    line_next  = line_hold;
    data_next  = data_hold;
    ram_addr   = base;
    ram_we     = 4'h0;
    ram_wdata  = 32'h0;
    ret_valid  = 1'b0;
    ret_last   = 2'b00;
    case (state)
      IDLE: begin
        if (wr_accept) begin
          state_next = WR_BUSY;
          base_next  = wr_base;
          beat_next  = '0;
          last_next  = wr_line ? LAST_LINE : '0;
          strb_next  = wr_wstrb;
          line_next  = wr_line;
          data_next  = wr_data;
        end else if (rd_accept) begin
          state_next = RD_WAIT;
          base_next  = rd_base;
          beat_next  = '0;
          last_next  = rd_line ? LAST_LINE : '0;
          wait_next  = WAIT_LOAD;
        end
      end
      RD_WAIT: begin
        // The first word is addressed on the final wait cycle so it is
        // on the RAM output exactly when the burst starts.
        ram_addr = base;
        if (wait_cnt == 4'd0) state_next = RD_BURST;
        else                  wait_next  = wait_cnt - 4'd1;
      end
      RD_BURST: begin
        // Prefetch the following word while the current one is returned
        ret_valid = 1'b1;
        ram_addr  = base + AW'(beat) + AW'(1);
        if (beat == last) begin
          ret_last   = 2'b01;
          state_next = IDLE;
        end else begin
          beat_next = beat + IW'(1);
        end
      end
      WR_BUSY: begin
        ram_addr  = base + AW'(beat);
        ram_we    = line_hold ? 4'hF : strb_hold;
        ram_wdata = hold_word[beat];
        if (beat == last) state_next = IDLE;
        else              beat_next  = beat + IW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  bram #(
    .DEPTH     (MEM_WORDS),
    .WIDTH     (32),
    .WRITE_BYTE(1)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for the cache memory responder: reset values, read latency
// and beat ordering, line and strobed writes, write priority, mid-burst reset.
module tb_cache_mem_responder;
  import cache_if_pkg::*;

  logic         clk;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [1:0]   ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_data  [8];
  logic [1:0]  cap_last  [8];
  int          cap_cycle [8];
  int          cap_n;
  int          cap_wait;
  bit          rdy_low_ok;
  int          wr_low;

  cache_mem_responder #(
    .BYTES_PER_LINE(16),
    .MEM_WORDS     (16384),
    .RD_LATENCY    (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rd_req   (rd_req),
    .rd_type  (rd_type),
    .rd_addr  (rd_addr),
    .rd_rdy   (rd_rdy),
    .ret_valid(ret_valid),
    .ret_last (ret_last),
    .ret_data (ret_data),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one write and wait for the responder to return to IDLE
  task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    int n;
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    n = 0;
    while (wr_rdy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    wr_req = 1'b0;
    wr_low = 0;
    n = 0;
    while (wr_rdy !== 1'b1 && n < 50) begin wr_low++; @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wr_done_timeout addr=%h got wr_rdy=%b want 1", a, wr_rdy);
    end
    $display("write type=%b addr=%h strb=%h busy_cycles=%0d", t, a, s, wr_low);
  endtask

  // Issue one read and capture every returned beat with its cycle offset
  task automatic do_read(input logic [2:0] t, input logic [31:0] a);
    int  n;
    int  e;
    bit  done;
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    cap_n = 0; cap_wait = 0; rdy_low_ok = 1'b1; done = 1'b0;
    n = 0;
    while (rd_rdy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; cap_wait++; end
    @(posedge clk); #1;
    rd_req = 1'b0;
    e = 0;
    while (!done && e <= 40) begin
      if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0) rdy_low_ok = 1'b0;
      if (ret_valid === 1'b1 && cap_n < 8) begin
        cap_data[cap_n]  = ret_data;
        cap_last[cap_n]  = ret_last;
        cap_cycle[cap_n] = e;
        cap_n++;
        if (ret_last[0] === 1'b1 || cap_n == 8) done = 1'b1;
      end
      @(posedge clk); #1;
      e++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL rd_done_timeout addr=%h got beats=%0d want final beat", a, cap_n);
    end
    $display("read type=%b addr=%h beats=%0d first_cycle=%0d data0=%h",
             t, a, cap_n, (cap_n > 0) ? cap_cycle[0] : -1, cap_data[0]);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rd_rdy !== 1'b0)     begin errors++; $display("FAIL reset_rd_rdy got %b want 0", rd_rdy); end
    checks++; if (wr_rdy !== 1'b0)     begin errors++; $display("FAIL reset_wr_rdy got %b want 0", wr_rdy); end
    checks++; if (ret_valid !== 1'b0)  begin errors++; $display("FAIL reset_ret_valid got %b want 0", ret_valid); end
    checks++; if (ret_last !== 2'b00)  begin errors++; $display("FAIL reset_ret_last got %b want 00", ret_last); end
    checks++; if (ret_data !== 32'h0)  begin errors++; $display("FAIL reset_ret_data got %h want 0", ret_data); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (wr_rdy !== 1'b1)     begin errors++; $display("FAIL idle_wr_rdy got %b want 1", wr_rdy); end
    checks++; if (rd_rdy !== 1'b1)     begin errors++; $display("FAIL idle_rd_rdy got %b want 1", rd_rdy); end
    $display("reset test done");
  endtask

  task automatic test_byte_read();
    do_write(TYPE_WORD, 32'h0000_0400, 4'hF, {96'h0, 32'hDEAD_BEEF});
    do_read(TYPE_BYTE, 32'h0000_0402);
    checks++; if (cap_n !== 1)                 begin errors++; $display("FAIL byte_beats got %0d want 1", cap_n); end
    checks++; if (cap_cycle[0] !== 2)          begin errors++; $display("FAIL byte_latency got %0d want 2", cap_cycle[0]); end
    checks++; if (cap_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byte_data got %h want deadbeef", cap_data[0]); end
    checks++; if (cap_last[0] !== 2'b01)       begin errors++; $display("FAIL byte_last got %b want 01", cap_last[0]); end
    checks++; if (rdy_low_ok !== 1'b1)         begin errors++; $display("FAIL byte_rdy_low got %b want 1", rdy_low_ok); end
  endtask

  task automatic test_line_read();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333; exp_w[3] = 32'h4444_4444;
    for (int k = 0; k < 4; k++)
      do_write(TYPE_WORD, 32'h0000_0100 + 32'(4*k), 4'hF, {96'h0, exp_w[k]});
    do_read(TYPE_LINE, 32'h0000_010C);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL line_beats got %0d want 4", cap_n); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_w[k]) begin errors++; $display("FAIL line_data%0d got %h want %h", k, cap_data[k], exp_w[k]); end
      checks++;
      if (cap_last[k] !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL line_last%0d got %b want %b", k, cap_last[k], (k == 3) ? 2'b01 : 2'b00); end
      checks++;
      if (cap_cycle[k] !== 2 + k) begin errors++; $display("FAIL line_cycle%0d got %0d want %0d", k, cap_cycle[k], 2 + k); end
    end
    checks++; if (rdy_low_ok !== 1'b1) begin errors++; $display("FAIL line_rdy_low got %b want 1", rdy_low_ok); end
  endtask

  task automatic test_line_write();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA000_0000; exp_w[1] = 32'hA111_1111;
    exp_w[2] = 32'hA222_2222; exp_w[3] = 32'hA333_3333;
    // Strobe deliberately zero: line writes enable every byte
    do_write(TYPE_LINE, 32'h0000_0200, 4'h0, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
    checks++; if (wr_low !== 4) begin errors++; $display("FAIL linewr_busy got %0d want 4", wr_low); end
    do_read(TYPE_LINE, 32'h0000_0200);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL linewr_beats got %0d want 4", cap_n); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_w[k]) begin errors++; $display("FAIL linewr_data%0d got %h want %h", k, cap_data[k], exp_w[k]); end
    end
  endtask

  task automatic test_strobe();
    do_write(TYPE_WORD, 32'h0000_0300, 4'hF, 128'h0);
    do_write(TYPE_WORD, 32'h0000_0300, 4'b0110, {96'h5555_6666_7777_8888_9999_0000, 32'hAABB_CCDD});
    checks++; if (wr_low !== 1) begin errors++; $display("FAIL strobe_busy got %0d want 1", wr_low); end
    do_read(TYPE_WORD, 32'h0000_0300);
    checks++; if (cap_data[0] !== 32'h00BB_CC00) begin errors++; $display("FAIL strobe_data got %h want 00bbcc00", cap_data[0]); end
  endtask

  task automatic test_back_to_back();
    // Reserved type 011 is a plain word write
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0500;
    wr_req = 1'b1; wr_type = 3'b011; wr_addr = 32'h0000_0500; wr_wstrb = 4'hF;
    wr_data = {96'h0, 32'h1234_5678};
    #1;
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL prio_wr_rdy got %b want 1", wr_rdy); end
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL prio_rd_rdy got %b want 0", rd_rdy); end
    @(posedge clk); #1;
    wr_req = 1'b0;
    do_read(TYPE_WORD, 32'h0000_0500);
    checks++; if (cap_wait !== 1) begin errors++; $display("FAIL prio_rd_wait got %0d want 1", cap_wait); end
    checks++; if (cap_data[0] !== 32'h1234_5678) begin errors++; $display("FAIL prio_rd_data got %h want 12345678", cap_data[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_0100;
    @(posedge clk); #1;
    rd_req = 1'b0;
    n = 0;
    while (ret_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    checks++; if (ret_data !== 32'h2222_2222) begin errors++; $display("FAIL mid_beat2 got %h want 22222222", ret_data); end
    resetn = 1'b0;
    #1;
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL mid_ret_valid got %b want 0", ret_valid); end
    checks++; if (ret_data !== 32'h0) begin errors++; $display("FAIL mid_ret_data got %h want 0", ret_data); end
    checks++; if (rd_rdy !== 1'b0)    begin errors++; $display("FAIL mid_rd_rdy got %b want 0", rd_rdy); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (rd_rdy !== 1'b1)    begin errors++; $display("FAIL post_rd_rdy got %b want 1", rd_rdy); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL post_ret_valid got %b want 0", ret_valid); end
    do_read(TYPE_LINE, 32'h0000_0108);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL post_beats got %0d want 4", cap_n); end
    checks++; if (cap_data[1] !== 32'h2222_2222) begin errors++; $display("FAIL post_data1 got %h want 22222222", cap_data[1]); end
    checks++; if (cap_data[3] !== 32'h4444_4444) begin errors++; $display("FAIL post_data3 got %h want 44444444", cap_data[3]); end
    $display("mid-burst reset test done");
  endtask

  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = 128'h0;
    test_reset();
    test_byte_read();
    test_line_read();
    test_line_write();
    test_strobe();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
